// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue stage: command record, sequencer states
// and a helper that packs a command from its loose fields.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OPC_W  = 5;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OPC_W-1:0]  opcode;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } seq_state_e;

   function automatic alu_cmd_t make_cmd(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [OPC_W-1:0]  opcode);
      alu_cmd_t cmd;
      cmd.a      = a;
      cmd.b      = b;
      cmd.opcode = opcode;
      return cmd;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry command FIFO; pointers wrap naturally because DEPTH is a power of two.
// A push is ignored while full and a pop is ignored while empty.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  alu_cmd_t                     push_cmd,
   input  logic                         pop,
   output alu_cmd_t                     head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   alu_cmd_t          mem_q [DEPTH];
   alu_cmd_t          mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              do_push;
   logic              do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];
   assign level   = level_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_cmd;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the combinational ALU: buffers commands, drives the ALU from registers,
// waits SETTLE cycles, captures the result and hands it back over a valid/ready port.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [DATA_W-1:0]            cmd_a,
   input  logic [DATA_W-1:0]            cmd_b,
   input  logic [OPC_W-1:0]             cmd_opcode,
   output logic [DATA_W-1:0]            alu_a,
   output logic [DATA_W-1:0]            alu_b,
   output logic [OPC_W-1:0]             alu_opcode,
   input  logic [DATA_W-1:0]            alu_out,
   input  logic                         alu_carryout,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [DATA_W-1:0]            res_data,
   output logic                         res_carry,
   output logic [OPC_W-1:0]             res_opcode,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   localparam int LVL_W  = $clog2(DEPTH + 1);
   localparam int WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(SETTLE - 1);

   if (SETTLE < 1) begin : g_settle_check
      $error("alu_op_sequencer: SETTLE must be at least 1");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("alu_op_sequencer: DEPTH must be a power of two, at least 2");
   end

   seq_state_e         state_q, state_d;
   logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
   logic [DATA_W-1:0]  alu_a_q, alu_a_d;
   logic [DATA_W-1:0]  alu_b_q, alu_b_d;
   logic [OPC_W-1:0]   alu_opcode_q, alu_opcode_d;
   logic [DATA_W-1:0]  res_data_q, res_data_d;
   logic               res_carry_q, res_carry_d;
   logic [OPC_W-1:0]   res_opcode_q, res_opcode_d;
   logic               res_valid_q, res_valid_d;
   logic               armed_q, armed_d;

   logic               fifo_push;
   logic               fifo_full;
   logic               fifo_empty;
   logic               issue;
   logic [LVL_W-1:0]   fifo_count;
   alu_cmd_t           head_cmd;

   // cmd_ready stays low until the first edge after reset release.
   assign cmd_ready = armed_q && !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;

   alu_cmd_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_cmd (make_cmd(cmd_a, cmd_b, cmd_opcode)),
      .pop      (issue),
      .head     (head_cmd),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_opcode_d = alu_opcode_q;
      res_data_d   = res_data_q;
      res_carry_d  = res_carry_q;
      res_opcode_d = res_opcode_q;
      res_valid_d  = res_valid_q;
      armed_d      = 1'b1;
      issue        = 1'b0;
      case (state_q)
         IDLE: issue = !fifo_empty;
         WAIT: begin
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - 1'b1;
            end else begin
               res_data_d   = alu_out;
               res_carry_d  = alu_carryout;
               res_opcode_d = alu_opcode_q;
               res_valid_d  = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               issue       = !fifo_empty;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // The ALU operand registers only move when a command is popped.
      if (issue) begin
         alu_a_d      = head_cmd.a;
         alu_b_d      = head_cmd.b;
         alu_opcode_d = head_cmd.opcode;
         wcnt_d       = WCNT_INIT;
         state_d      = WAIT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wcnt_q       <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_opcode_q <= '0;
         res_data_q   <= '0;
         res_carry_q  <= 1'b0;
         res_opcode_q <= '0;
         res_valid_q  <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_opcode_q <= alu_opcode_d;
         res_data_q   <= res_data_d;
         res_carry_q  <= res_carry_d;
         res_opcode_q <= res_opcode_d;
         res_valid_q  <= res_valid_d;
         armed_q      <= armed_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opcode_q;
   assign res_data   = res_data_q;
   assign res_carry  = res_carry_q;
   assign res_opcode = res_opcode_q;
   assign res_valid  = res_valid_q;
   assign fifo_level = fifo_count;
   assign busy       = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Two sequencers (SETTLE=1 and SETTLE=3) with adder ALU stubs, directed scenarios plus
// random traffic, scored against an in-order queue of expected sums.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        cmd_valid [2];
   logic        cmd_ready [2];
   logic [31:0] cmd_a [2];
   logic [31:0] cmd_b [2];
   logic [4:0]  cmd_opcode [2];
   logic [31:0] alu_a [2];
   logic [31:0] alu_b [2];
   logic [4:0]  alu_opcode [2];
   logic [31:0] alu_out [2];
   logic        alu_carry [2];
   logic        res_valid [2];
   logic        res_ready [2];
   logic [31:0] res_data [2];
   logic        res_carry [2];
   logic [4:0]  res_opcode [2];
   logic        busy [2];
   logic [2:0]  fifo_level [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [37:0] exp_q [2][$];
   int          hs_cyc [2][$];
   logic        prev_rv [2];
   logic        prev_hs [2];
   logic [37:0] prev_res [2];
   logic [68:0] prev_alu [2];
   int          alu_chg [2];

   assign {alu_carry[0], alu_out[0]} = {1'b0, alu_a[0]} + {1'b0, alu_b[0]};
   assign {alu_carry[1], alu_out[1]} = {1'b0, alu_a[1]} + {1'b0, alu_b[1]};

   alu_op_sequencer #(.DEPTH(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_opcode(cmd_opcode[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_opcode(alu_opcode[0]),
      .alu_out(alu_out[0]), .alu_carryout(alu_carry[0]),
      .res_valid(res_valid[0]), .res_ready(res_ready[0]),
      .res_data(res_data[0]), .res_carry(res_carry[0]), .res_opcode(res_opcode[0]),
      .busy(busy[0]), .fifo_level(fifo_level[0])
   );

   alu_op_sequencer #(.DEPTH(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_opcode(cmd_opcode[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_opcode(alu_opcode[1]),
      .alu_out(alu_out[1]), .alu_carryout(alu_carry[1]),
      .res_valid(res_valid[1]), .res_ready(res_ready[1]),
      .res_data(res_data[1]), .res_carry(res_carry[1]), .res_opcode(res_opcode[1]),
      .busy(busy[1]), .fifo_level(fifo_level[1])
   );

   function automatic logic [37:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return {op, sum[32], sum[31:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one command and hold it until the port accepts it; returns #1 after the accepting edge.
   task automatic applyStimulus(input int u, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] op);
      int n;
      n = 0;
      cmd_valid[u]  = 1'b1;
      cmd_a[u]      = a;
      cmd_b[u]      = b;
      cmd_opcode[u] = op;
      @(negedge clk);
      while (!cmd_ready[u] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready[u]) checkOutput("push_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      cmd_valid[u] = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((busy[0] || busy[1]) && n < budget) begin
         step(1);
         n++;
      end
      checkOutput("drain_idle", {63'd0, busy[0] | busy[1]}, 64'd0);
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard: inputs only change just after a rising edge, so what is seen here is
   // exactly what the next rising edge will act on.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         logic [37:0] got;
         logic        hs;
         got = {res_opcode[u], res_carry[u], res_data[u]};
         if (!rst_n) begin
            exp_q[u].delete();
            prev_rv[u]  = 1'b0;
            prev_hs[u]  = 1'b0;
            prev_alu[u] = '0;
         end else begin
            if (prev_rv[u] && !prev_hs[u])
               checkOutput("res_hold", {25'd0, res_valid[u], got}, {25'd0, 1'b1, prev_res[u]});
            if (cmd_valid[u] && cmd_ready[u])
               exp_q[u].push_back(aluModel(cmd_a[u], cmd_b[u], cmd_opcode[u]));
            hs = res_valid[u] && res_ready[u];
            if (hs) begin
               if (exp_q[u].size() == 0) checkOutput("spurious_result", 64'd1, 64'd0);
               else checkOutput("result", {26'd0, got}, {26'd0, exp_q[u].pop_front()});
               hs_cyc[u].push_back(cyc);
            end
            if ({alu_a[u], alu_b[u], alu_opcode[u]} != prev_alu[u]) alu_chg[u]++;
            prev_alu[u] = {alu_a[u], alu_b[u], alu_opcode[u]};
            prev_rv[u]  = res_valid[u];
            prev_hs[u]  = hs;
            prev_res[u] = got;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] r;
      logic        seen;
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         cmd_valid[u] = 0; cmd_a[u] = 0; cmd_b[u] = 0; cmd_opcode[u] = 0;
         res_ready[u] = 0; alu_chg[u] = 0;
      end
      step(2);
      checkOutput("rst_cmd_ready", {63'd0, cmd_ready[0]}, 64'd0);
      checkOutput("rst_res_valid", {63'd0, res_valid[0]}, 64'd0);
      checkOutput("rst_busy", {63'd0, busy[0]}, 64'd0);
      checkOutput("rst_level", {61'd0, fifo_level[0]}, 64'd0);
      checkOutput("rst_alu_a", {32'd0, alu_a[0]}, 64'd0);
      rst_n = 1'b1;
      step(2);
      checkOutput("ready_after_rst0", {63'd0, cmd_ready[0]}, 64'd1);
      checkOutput("ready_after_rst1", {63'd0, cmd_ready[1]}, 64'd1);

      $display("[TB] single command 5+3, SETTLE=1");
      applyStimulus(0, 32'h0000_0005, 32'h0000_0003, 5'h01);
      checkOutput("t1_busy", {63'd0, busy[0]}, 64'd1);
      step(1);
      checkOutput("t1_alu_a", {32'd0, alu_a[0]}, 64'h5);
      checkOutput("t1_alu_b", {32'd0, alu_b[0]}, 64'h3);
      checkOutput("t1_alu_op", {59'd0, alu_opcode[0]}, 64'h1);
      checkOutput("t1_valid_early", {63'd0, res_valid[0]}, 64'd0);
      step(1);
      checkOutput("t1_valid", {63'd0, res_valid[0]}, 64'd1);
      checkOutput("t1_data", {32'd0, res_data[0]}, 64'h8);
      checkOutput("t1_carry", {63'd0, res_carry[0]}, 64'd0);
      checkOutput("t1_opcode", {59'd0, res_opcode[0]}, 64'h1);
      res_ready[0] = 1'b1;
      step(1);
      res_ready[0] = 1'b0;
      checkOutput("t1_valid_drop", {63'd0, res_valid[0]}, 64'd0);

      $display("[TB] carry wrap FFFFFFFF+1");
      applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 5'h1F);
      step(2);
      checkOutput("t2_valid", {63'd0, res_valid[0]}, 64'd1);
      checkOutput("t2_data", {32'd0, res_data[0]}, 64'h0);
      checkOutput("t2_carry", {63'd0, res_carry[0]}, 64'd1);
      res_ready[0] = 1'b1;
      step(1);
      res_ready[0] = 1'b0;

      $display("[TB] fill FIFO with res_ready low");
      for (int i = 0; i < 5; i++) begin
         r = $urandom();
         applyStimulus(0, r, $urandom(), 5'(i + 3));
      end
      checkOutput("t3_level_full", {61'd0, fifo_level[0]}, 64'd4);
      checkOutput("t3_ready_full", {63'd0, cmd_ready[0]}, 64'd0);
      checkOutput("t3_valid_held", {63'd0, res_valid[0]}, 64'd1);
      res_ready[0] = 1'b1;
      step(1);
      res_ready[0] = 1'b0;
      checkOutput("t3_level_after_pop", {61'd0, fifo_level[0]}, 64'd3);
      checkOutput("t3_ready_after_pop", {63'd0, cmd_ready[0]}, 64'd1);
      step(1);
      checkOutput("t3_resp", {63'd0, res_valid[0]}, 64'd1);
      cmd_valid[0] = 1'b1; cmd_a[0] = 32'hCAFE_0001; cmd_b[0] = 32'h0000_1000; cmd_opcode[0] = 5'h0A;
      res_ready[0] = 1'b1;
      step(1);
      cmd_valid[0] = 1'b0;
      checkOutput("t3_level_push_pop", {61'd0, fifo_level[0]}, 64'd3);
      waitIdle(200);
      checkOutput("t3_all_results", {32'd0, 32'(exp_q[0].size())}, 64'd0);
      res_ready[0] = 1'b0;

      $display("[TB] back-to-back, SETTLE=3, res_ready held");
      res_ready[1] = 1'b1;
      hs_cyc[1].delete();
      alu_chg[1] = 0;
      for (int i = 0; i < 8; i++) begin
         r = $urandom();
         applyStimulus(1, {r[31:4], 4'(i + 1)}, $urandom(), 5'(i));
      end
      waitIdle(200);
      checkOutput("t4_count", {32'd0, 32'(hs_cyc[1].size())}, 64'd8);
      for (int i = 1; i < hs_cyc[1].size(); i++)
         checkOutput("t4_spacing", {32'd0, 32'(hs_cyc[1][i] - hs_cyc[1][i-1])}, 64'd4);
      checkOutput("t4_alu_changes", {32'd0, 32'(alu_chg[1])}, 64'd8);

      $display("[TB] reset during WAIT with two buffered");
      for (int i = 0; i < 3; i++) applyStimulus(1, 32'h100 + 32'(i), 32'h7, 5'h02);
      checkOutput("t5_level", {61'd0, fifo_level[1]}, 64'd2);
      checkOutput("t5_waiting", {63'd0, res_valid[1]}, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_alu", {alu_a[1], alu_b[1]}, 64'd0);
      checkOutput("t5_ctl", {56'd0, cmd_ready[1], res_valid[1], busy[1], fifo_level[1], res_carry[1],
                             1'b0}, 64'd0);
      checkOutput("t5_res", {27'd0, res_opcode[1], res_data[1]}, 64'd0);
      checkOutput("t5_alu_op", {59'd0, alu_opcode[1]}, 64'd0);
      @(posedge clk); #1;
      step(1);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (res_valid[1]) seen = 1'b1;
      end
      checkOutput("t5_no_result", {63'd0, seen}, 64'd0);
      checkOutput("t5_level_after", {61'd0, fifo_level[1]}, 64'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         for (int u = 0; u < 2; u++) begin
            cmd_valid[u]  = ($urandom_range(0, 2) != 0);
            cmd_a[u]      = $urandom();
            cmd_b[u]      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            cmd_opcode[u] = 5'($urandom_range(0, 31));
            res_ready[u]  = ($urandom_range(0, 3) != 0);
         end
         step(1);
      end
      for (int u = 0; u < 2; u++) begin
         cmd_valid[u] = 1'b0;
         res_ready[u] = 1'b1;
      end
      waitIdle(300);
      step(2);
      checkOutput("rand_left0", {32'd0, 32'(exp_q[0].size())}, 64'd0);
      checkOutput("rand_left1", {32'd0, 32'(exp_q[1].size())}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
